// File: rtl/mm_result_collector.sv
// Result collector for the matrix-multiply datapath: banks per-lane sums,
// tracks per-row completion and streams complete rows out in row order.
module mm_result_collector #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int ROW_NUM        = 32,
  parameter  int COL_NUM        = 32,
  localparam int SUM_WIDTH      = DATA_WIDTH * 4,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [SUM_WIDTH*COL_NUM-1:0]  row_data_in,
  input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0] row_wraddr,
  input  logic [COL_NUM-1:0]            row_wr_en,
  output logic [SUM_WIDTH*COL_NUM-1:0]  out_data,
  output logic [ROW_ADDR_WIDTH-1:0]     out_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

  state_t                           state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0]        drain_ptr;
  logic [ROW_NUM-1:0][COL_NUM-1:0]  mask;
  logic                             err_q;
  logic [SUM_WIDTH-1:0]             bank [COL_NUM][ROW_NUM];

  logic [ROW_ADDR_WIDTH-1:0]        lane_addr [COL_NUM];
  logic [SUM_WIDTH-1:0]             lane_data [COL_NUM];
  logic [COL_NUM-1:0]               lane_ok;
  logic [COL_NUM-1:0]               lane_bad;
  logic                             handshake;

  // Zero-extended compare keeps the range check meaningful for non-power-of-two ROW_NUM.
  function automatic logic addr_oob(input logic [ROW_ADDR_WIDTH-1:0] a);
    return (32'(a) >= ROW_NUM);
  endfunction

  assign out_valid = (state_q == ACTIVE) && (&mask[drain_ptr]);
  assign out_row   = drain_ptr;
  assign busy      = (state_q == ACTIVE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign handshake = out_valid && out_ready;

  // Per-lane write classification; writes during a start cycle are dropped silently.
  always_comb begin
    lane_ok  = '0;
    lane_bad = '0;
    for (int c = 0; c < COL_NUM; c++) begin
      lane_addr[c] = row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
      lane_data[c] = row_data_in[c*SUM_WIDTH +: SUM_WIDTH];
      if (row_wr_en[c] && !start) begin
        if (state_q != ACTIVE) begin
          lane_bad[c] = 1'b1;
        end else if (addr_oob(lane_addr[c]) || (lane_addr[c] < drain_ptr)) begin
          lane_bad[c] = 1'b1;
        end else if (mask[lane_addr[c]][c]) begin
          lane_bad[c] = 1'b1;
        end else begin
          lane_ok[c] = 1'b1;
        end
      end else begin
        lane_bad[c] = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACTIVE; else state_d = IDLE;
      ACTIVE: begin
        if (start) begin
          state_d = ACTIVE;
        end else if (handshake && (drain_ptr == LAST_ROW)) begin
          state_d = DONE;
        end else begin
          state_d = ACTIVE;
        end
      end
      DONE:    if (start) state_d = ACTIVE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, drain pointer, completion masks and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      drain_ptr <= '0;
      mask      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        drain_ptr <= '0;
        mask      <= '0;
        err_q     <= 1'b0;
      end else begin
        if (|lane_bad) err_q <= 1'b1;
        for (int c = 0; c < COL_NUM; c++) begin
          if (lane_ok[c]) mask[lane_addr[c]][c] <= 1'b1;
        end
        // The drained row is full, so no lane_ok can target it; the clear always wins.
        if (handshake) begin
          mask[drain_ptr] <= '0;
          drain_ptr       <= (drain_ptr == LAST_ROW) ? '0 : drain_ptr + 1'b1;
        end
      end
    end
  end

  // Bank storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COL_NUM; c++) begin
      if (!reset && lane_ok[c]) bank[c][lane_addr[c]] <= lane_data[c];
    end
  end

  // Row read-out at the drain pointer.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COL_NUM; c++) begin
      out_data[c*SUM_WIDTH +: SUM_WIDTH] = bank[c][drain_ptr];
    end
  end

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed self-checking bench for mm_result_collector (ROW_NUM=4, COL_NUM=2).
module tb_mm_result_collector;
  localparam int DW = 8, RN = 4, CN = 2, SW = 32, AW = 2;

  logic clk = 1'b0;
  logic reset, start, out_ready, out_valid, busy, done, err;
  logic [SW*CN-1:0] row_data_in, out_data;
  logic [AW*CN-1:0] row_wraddr;
  logic [CN-1:0]    row_wr_en;
  logic [AW-1:0]    out_row;
  int tests = 0, fails = 0;
  logic [SW*CN-1:0] held;

  mm_result_collector #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) dut (
    .clk(clk), .reset(reset), .start(start), .row_data_in(row_data_in),
    .row_wraddr(row_wraddr), .row_wr_en(row_wr_en), .out_data(out_data),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic e0, input int a0, input int d0,
                    input logic e1, input int a1, input int d1);
    row_wr_en   = {e1, e0};
    row_wraddr  = {AW'(a1), AW'(a0)};
    row_data_in = {SW'(d1), SW'(d0)};
  endtask

  task automatic nowr();
    row_wr_en = 2'b00;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  function automatic logic [63:0] rowv(input int r, input int base);
    return {SW'(base + r*16 + 1), SW'(base + r*16)};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    row_data_in = '0; row_wraddr = '0; row_wr_en = '0;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_row",   64'(out_row),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(err),       64'd0);
    reset = 1'b0;

    // Basic in-order tile: each row written in one cycle, drained the next.
    out_ready = 1'b1;
    do_start();
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_v0", 64'(out_valid), 64'd0);
    for (int r = 0; r < RN; r++) begin
      wr(1'b1, r, r*16, 1'b1, r, r*16 + 1);
      step(); nowr();
      chk("basic_valid", 64'(out_valid), 64'd1);
      chk("basic_row",   64'(out_row),   64'(r));
      chk("basic_data",  out_data,       rowv(r, 0));
    end
    step();
    chk("basic_done",  64'(done),      64'd1);
    chk("basic_nbusy", 64'(busy),      64'd0);
    chk("basic_err",   64'(err),       64'd0);
    chk("basic_vdone", 64'(out_valid), 64'd0);

    // Out-of-order arrival: row 2, then row 0, then row 1.
    do_start();
    wr(1'b1, 2, 32'h120, 1'b1, 2, 32'h121); step(); nowr();
    chk("ooo_wait2", 64'(out_valid), 64'd0);
    wr(1'b1, 0, 32'h100, 1'b0, 0, 0); step(); nowr();
    chk("ooo_half0", 64'(out_valid), 64'd0);
    wr(1'b0, 0, 0, 1'b1, 0, 32'h101); step(); nowr();
    chk("ooo_v0",   64'(out_valid), 64'd1);
    chk("ooo_r0",   64'(out_row),   64'd0);
    chk("ooo_d0",   out_data,       rowv(0, 32'h100));
    wr(1'b1, 1, 32'h110, 1'b1, 1, 32'h111); step(); nowr();
    chk("ooo_r1",   64'(out_row),   64'd1);
    chk("ooo_d1",   out_data,       rowv(1, 32'h100));
    step();
    chk("ooo_v2",   64'(out_valid), 64'd1);
    chk("ooo_r2",   64'(out_row),   64'd2);
    chk("ooo_d2",   out_data,       rowv(2, 32'h100));
    step();
    chk("ooo_v3",   64'(out_valid), 64'd0);
    chk("ooo_r3",   64'(out_row),   64'd3);
    chk("ooo_err",  64'(err),       64'd0);

    // Split lanes on row 0 four cycles apart, then backpressure.
    out_ready = 1'b0;
    do_start();
    wr(1'b1, 0, 32'hA0, 1'b0, 0, 0); step(); nowr();
    chk("split_c5", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("split_gap", 64'(out_valid), 64'd0);
    end
    wr(1'b0, 0, 0, 1'b1, 0, 32'hA1); step(); nowr();
    chk("split_c10", 64'(out_valid), 64'd1);
    held = 64'h0000_00A1_0000_00A0;
    wr(1'b1, 1, 32'hB0, 1'b1, 1, 32'hB1); step(); nowr();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_row",   64'(out_row),   64'd0);
      chk("bp_data",  out_data,       held);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel1_row", 64'(out_row),   64'd1);
    chk("bp_rel1_v",   64'(out_valid), 64'd1);
    chk("bp_rel1_d",   out_data,       64'h0000_00B1_0000_00B0);
    step();
    chk("bp_rel2_row", 64'(out_row),   64'd2);
    chk("bp_rel2_v",   64'(out_valid), 64'd0);

    // Duplicate write is ignored and flagged.
    do_reset();
    out_ready = 1'b0;
    do_start();
    wr(1'b1, 1, 32'h55, 1'b1, 1, 32'h56); step(); nowr();
    chk("dup_err0", 64'(err), 64'd0);
    wr(1'b1, 1, 32'hAA, 1'b0, 0, 0); step(); nowr();
    chk("dup_err1", 64'(err), 64'd1);
    wr(1'b1, 0, 32'h01, 1'b1, 0, 32'h02); step(); nowr();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("dup_row1", 64'(out_row), 64'd1);
    chk("dup_data", out_data, 64'h0000_0056_0000_0055);

    // Late write to a drained row.
    do_reset();
    out_ready = 1'b1;
    do_start();
    wr(1'b1, 0, 32'h7, 1'b1, 0, 32'h8); step(); nowr();
    step();
    chk("late_ptr",  64'(out_row), 64'd1);
    chk("late_err0", 64'(err),     64'd0);
    wr(1'b1, 0, 32'h9, 1'b0, 0, 0); step(); nowr();
    chk("late_err1", 64'(err),     64'd1);
    do_start();
    chk("start_clr_err", 64'(err),  64'd0);
    chk("start_busy",    64'(busy), 64'd1);

    // Write in IDLE flags; write in the start cycle is dropped silently.
    do_reset();
    wr(1'b1, 0, 32'h3, 1'b0, 0, 0); step(); nowr();
    chk("idle_err",  64'(err),  64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    wr(1'b1, 0, 32'h3, 1'b0, 0, 0);
    do_start(); nowr();
    chk("startwr_err", 64'(err), 64'd0);
    wr(1'b0, 0, 0, 1'b1, 0, 32'h4); step(); nowr();
    chk("startwr_ign", 64'(out_valid), 64'd0);

    // Restart mid-tile with row 1 partially written.
    do_reset();
    out_ready = 1'b1;
    do_start();
    wr(1'b1, 1, 32'hDEAD, 1'b0, 0, 0); step(); nowr();
    do_start();
    chk("rs_row", 64'(out_row),   64'd0);
    chk("rs_v",   64'(out_valid), 64'd0);
    for (int r = 0; r < RN; r++) begin
      wr(1'b1, r, 32'h200 + r*16, 1'b1, r, 32'h200 + r*16 + 1);
      step(); nowr();
      chk("rs_valid", 64'(out_valid), 64'd1);
      chk("rs_data",  out_data,       rowv(r, 32'h200));
    end
    step();
    chk("rs_done", 64'(done), 64'd1);
    chk("rs_err",  64'(err),  64'd0);

    // Reset mid-tile with valid and err both set.
    out_ready = 1'b0;
    do_start();
    wr(1'b1, 0, 32'h1, 1'b1, 0, 32'h2); step(); nowr();
    wr(1'b1, 0, 32'h5, 1'b0, 0, 0); step(); nowr();
    chk("mr_pre_v",   64'(out_valid), 64'd1);
    chk("mr_pre_err", 64'(err),       64'd1);
    do_reset();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_row",   64'(out_row),   64'd0);
    chk("mr_busy",  64'(busy),      64'd0);
    chk("mr_done",  64'(done),      64'd0);
    chk("mr_err",   64'(err),       64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
